// File: rtl/axi_wr_slave.sv
// ============================================================================
// axi_wr_slave : AXI4 write responder (INCR bursts) backed by a word RAM,
//                with a registered read-first debug read port.
// Option macro : AXI_WR_SLAVE_STRB_EN (honour WSTRB byte enables)
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_wr_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int MEM_AW           = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [MEM_AW-1:0]             dbg_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]   dbg_rdata
);

  localparam int BYTES = C_AXI_DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                st_q, st_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [MEM_AW-1:0]     ptr_q, ptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [C_AXI_DATA_WIDTH-1:0] dbg_rdata_q;
  logic [C_AXI_DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

  logic aw_hs, w_hs, b_hs;
  logic unused_bits;

  assign aw_hs = awready_q & S_AXI_AWVALID;
  assign w_hs  = wready_q  & S_AXI_WVALID;
  assign b_hs  = bvalid_q  & S_AXI_BREADY;

  // Only the word-index slice of AWADDR matters; strobes may be ignored.
  assign unused_bits = ^{S_AXI_AWADDR, S_AXI_WSTRB};

  always_comb begin
    st_d  = st_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (st_q)
      IDLE: if (aw_hs) begin
        ptr_d = S_AXI_AWADDR[BSH +: MEM_AW];
        cnt_d = S_AXI_AWLEN;
        err_d = 1'b0;
        st_d  = DATA;
      end
      DATA: if (w_hs) begin
        ptr_d = ptr_q + MEM_AW'(1);
        cnt_d = cnt_q - 8'd1;
        // WLAST must coincide exactly with the AWLEN-defined final beat.
        if (S_AXI_WLAST != (cnt_q == 8'd0)) err_d = 1'b1;
        if (cnt_q == 8'd0) st_d = RESP;
      end
      RESP: if (b_hs) st_d = IDLE;
      default: st_d = IDLE;
    endcase

    awready_d = (st_d == IDLE);
    wready_d  = (st_d == DATA);
    bvalid_d  = (st_d == RESP);
    bresp_d   = (st_d == RESP && err_d) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      ptr_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // RAM is never reset; a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    dbg_rdata_q <= mem[dbg_addr];
    if (rst_n && w_hs) begin
`ifdef AXI_WR_SLAVE_STRB_EN
      for (int i = 0; i < BYTES; i++) begin
        if (S_AXI_WSTRB[i]) mem[ptr_q][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
`else
      mem[ptr_q] <= S_AXI_WDATA;
`endif
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign dbg_rdata     = dbg_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_slave.sv
// Directed self-checking bench for axi_wr_slave (default 32-bit, MEM_AW=10).
`default_nettype none

module tb_axi_wr_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int total = 0;
  int bad   = 0;

  axi_wr_slave #(.C_AXI_DATA_WIDTH(32), .MEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
    dbg_addr = a;
    tick();
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len);
    bit got = 0;
    awaddr = a; awlen = len; awvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (awready) begin
        got = 1;
        tick();
        break;
      end
      tick();
    end
    awvalid = 1'b0;
    if (!got) chk("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit got = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (wready) begin
        got = 1;
        tick();
        break;
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (!got) chk("w_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_burst(input logic [31:0] a, input logic [7:0] len,
                            input logic [31:0] base, input int last_at,
                            input logic [3:0] s, output logic [1:0] resp);
    bit got = 0;
    resp = 2'b11;
    do_aw(a, len);
    for (int i = 0; i <= int'(len); i++) w_beat(base + i, s, (i == last_at));
    bready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (bvalid) begin
        got = 1;
        resp = bresp;
        tick();
        break;
      end
      tick();
    end
    if (!got) chk("b_timeout", 32'd0, 32'd1);
  endtask

  logic [1:0] r;
  bit         wr_hi;

  initial begin
    rst_n = 1'b0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1; dbg_addr = '0;

    // Reset state
    tick(); tick();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);

    // Single beat, peers always ready: AW at c0, W at c1, B at c2
    rst_n = 1'b1;
    awaddr = 32'h10; awlen = 8'd0; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    chk("c0_awready", {31'd0, awready}, 32'd1);
    chk("c0_wready",  {31'd0, wready},  32'd0);
    tick();
    awvalid = 1'b0;
    chk("c1_awready", {31'd0, awready}, 32'd0);
    chk("c1_wready",  {31'd0, wready},  32'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk("c2_wready", {31'd0, wready}, 32'd0);
    chk("c2_bvalid", {31'd0, bvalid}, 32'd1);
    chk("c2_bresp",  {30'd0, bresp},  32'd0);
    tick();
    chk("c3_bvalid",  {31'd0, bvalid},  32'd0);
    chk("c3_awready", {31'd0, awready}, 32'd1);
    rd(10'd4, 32'hDEADBEEF, "single_mem4");

    // 256-beat burst, WVALID toggling, BREADY held low for 3 cycles
    do_aw(32'h0, 8'hFF);
    wr_hi = 1;
    bready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (!wready) wr_hi = 0;
      wdata = i; wlast = (i == 255); wvalid = 1'b1;
      tick();
      wvalid = 1'b0; wlast = 1'b0;
      if (i < 255) begin
        if (!wready) wr_hi = 0;
        tick();
      end
    end
    chk("b256_wready_held", {31'd0, wr_hi}, 32'd1);
    chk("b256_wready_end",  {31'd0, wready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("b256_bvalid_hold", {31'd0, bvalid}, 32'd1);
      chk("b256_bresp_hold",  {30'd0, bresp},  32'd0);
      tick();
    end
    chk("b256_bvalid_still", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    tick();
    chk("b256_bvalid_done", {31'd0, bvalid}, 32'd0);
    rd(10'd0,   32'd0,   "b256_mem0");
    rd(10'd1,   32'd1,   "b256_mem1");
    rd(10'd128, 32'd128, "b256_mem128");
    rd(10'd255, 32'd255, "b256_mem255");

    // Wrap-around past the top of the memory
    send_burst(32'hFF8, 8'd3, 32'hAAAA0000, 3, 4'hF, r);
    chk("wrap_bresp", {30'd0, r}, 32'd0);
    rd(10'd1022, 32'hAAAA0000, "wrap_mem1022");
    rd(10'd1023, 32'hAAAA0001, "wrap_mem1023");
    rd(10'd0,    32'hAAAA0002, "wrap_mem0");
    rd(10'd1,    32'hAAAA0003, "wrap_mem1");

    // Early WLAST: all four beats still consumed
    send_burst(32'h100, 8'd3, 32'hB0000000, 1, 4'hF, r);
    chk("early_last_bresp", {30'd0, r}, 32'd2);
    rd(10'd67, 32'hB0000003, "early_last_mem67");

    // Missing WLAST: burst still ends after AWLEN+1 beats
    send_burst(32'h200, 8'd1, 32'hC0000000, -1, 4'hF, r);
    chk("no_last_bresp",   {30'd0, r}, 32'd2);
    chk("no_last_awready", {31'd0, awready}, 32'd1);
    rd(10'd129, 32'hC0000001, "no_last_mem129");

    // Reset in the middle of an 8-beat burst
    send_burst(32'h30C, 8'd0, 32'h11111111, 0, 4'hF, r);
    do_aw(32'h300, 8'd7);
    for (int i = 0; i < 3; i++) w_beat(32'h5000 + i, 4'hF, 1'b0);
    rst_n = 1'b0; wdata = 32'h5003; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("mid_rst_awready", {31'd0, awready}, 32'd0);
    chk("mid_rst_wready",  {31'd0, wready},  32'd0);
    chk("mid_rst_bvalid",  {31'd0, bvalid},  32'd0);
    rst_n = 1'b1;
    rd(10'd192, 32'h5000,     "mid_rst_mem192");
    rd(10'd194, 32'h5002,     "mid_rst_mem194");
    rd(10'd195, 32'h11111111, "mid_rst_mem195");
    send_burst(32'h400, 8'd1, 32'hD0000000, 1, 4'hF, r);
    chk("post_rst_bresp", {30'd0, r}, 32'd0);
    rd(10'd257, 32'hD0000001, "post_rst_mem257");

    // Byte strobes
    send_burst(32'h14, 8'd0, 32'hFFFFFFFF, 0, 4'hF, r);
    send_burst(32'h14, 8'd0, 32'h12345678, 0, 4'b0101, r);
    chk("strb_bresp", {30'd0, r}, 32'd0);
`ifdef AXI_WR_SLAVE_STRB_EN
    rd(10'd5, 32'hFF34FF78, "strb_mem5");
`else
    rd(10'd5, 32'h12345678, "strb_mem5");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
